// File: rtl/signed_extender_5to16.sv
// signed_extender_5to16
// Immediate/offset sign-extension unit for an LC-3 style datapath.
//   - out    : combinational sign extension of the primary field `in`
//   - ir_ext : combinational sign extension of an instruction-word field picked by `sel`
//   - out_q  : registered copy of either result, loaded under `ld`
// Both combinational paths are clock-independent and stay valid while reset is held.

module signed_extender_5to16 #(
    parameter int IN_W  = 5,   // primary field width, 1..OUT_W
    parameter int OUT_W = 16   // width of the primary extended result
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
    input  logic [15:0]      ir,
    input  logic [1:0]       sel,
    output logic [15:0]      ir_ext,
    input  logic             src,
    input  logic             ld,
    output logic [15:0]      out_q,
    output logic             out_q_vld
);

    // Field select encodings for the instruction-word path.
    localparam logic [1:0] SEL_IMM5    = 2'd0;
    localparam logic [1:0] SEL_OFFSET6 = 2'd1;
    localparam logic [1:0] SEL_PCOFF9  = 2'd2;
    localparam logic [1:0] SEL_PCOFF11 = 2'd3;

    logic [OUT_W-1:0] w_out;
    logic [15:0]      w_out_16;
    logic [15:0]      w_imm5_ext;
    logic [15:0]      w_off6_ext;
    logic [15:0]      w_pcoff9_ext;
    logic [15:0]      w_pcoff11_ext;
    logic [15:0]      w_ir_ext;
    logic [15:0]      w_load_val;
    logic [15:0]      r_out_q;
    logic             r_out_q_vld;

    // ------------------------------------------------------------------
    // Primary path: bit-by-bit extension. Low IN_W bits copy the field,
    // every bit above replicates the field MSB. Building it per bit keeps
    // the IN_W == OUT_W case legal (no zero-width replication).
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_out_bit
            if (gi < IN_W) begin : g_copy
                assign w_out[gi] = in[gi];
            end else begin : g_sign
                assign w_out[gi] = in[IN_W-1];
            end
        end
    endgenerate

    assign out = w_out;

    // ------------------------------------------------------------------
    // The registered result is always 16 bits wide; adapt the primary
    // result to that width (sign-extend if narrower, truncate if wider).
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_out16_bit
            if (gi < OUT_W) begin : g_copy
                assign w_out_16[gi] = w_out[gi];
            end else begin : g_sign
                assign w_out_16[gi] = w_out[OUT_W-1];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Instruction-word path: all four candidate extensions are formed in
    // parallel, then one is picked. Bits of ir above the chosen field
    // never reach the selected result.
    // ------------------------------------------------------------------
    assign w_imm5_ext    = {{11{ir[4]}},  ir[4:0]};
    assign w_off6_ext    = {{10{ir[5]}},  ir[5:0]};
    assign w_pcoff9_ext  = {{7{ir[8]}},   ir[8:0]};
    assign w_pcoff11_ext = {{5{ir[10]}},  ir[10:0]};

    // Select the extended instruction field.
    always_comb begin
        w_ir_ext = w_imm5_ext;
        case (sel)
            SEL_IMM5:    w_ir_ext = w_imm5_ext;
            SEL_OFFSET6: w_ir_ext = w_off6_ext;
            SEL_PCOFF9:  w_ir_ext = w_pcoff9_ext;
            SEL_PCOFF11: w_ir_ext = w_pcoff11_ext;
            default:     w_ir_ext = 16'hxxxx;
        endcase
    end

    assign ir_ext = w_ir_ext;

    // Choose which result feeds the pipeline register.
    assign w_load_val = src ? w_ir_ext : w_out_16;

    // Pipeline register: async clear, load on ld, valid flag sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_q     <= 16'h0000;
            r_out_q_vld <= 1'b0;
        end else if (ld) begin
            r_out_q     <= w_load_val;
            r_out_q_vld <= 1'b1;
        end
    end

    assign out_q     = r_out_q;
    assign out_q_vld = r_out_q_vld;

endmodule

// File: tb/tb_signed_extender_5to16.sv
// Directed testbench for signed_extender_5to16: combinational extension
// with the clock stopped, instruction-field extraction, then the register
// path including asynchronous reset behaviour.

module tb_signed_extender_5to16;

    logic        clk;
    logic        clk_en;
    logic        rst_n;
    logic [4:0]  tb_in;
    logic [15:0] tb_out;
    logic [15:0] tb_ir;
    logic [1:0]  tb_sel;
    logic [15:0] tb_ir_ext;
    logic        tb_src;
    logic        tb_ld;
    logic [15:0] tb_out_q;
    logic        tb_out_q_vld;

    int total;
    int bad;

    signed_extender_5to16 #(.IN_W(5), .OUT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (tb_in),
        .out       (tb_out),
        .ir        (tb_ir),
        .sel       (tb_sel),
        .ir_ext    (tb_ir_ext),
        .src       (tb_src),
        .ld        (tb_ld),
        .out_q     (tb_out_q),
        .out_q_vld (tb_out_q_vld)
    );

    // Clock only toggles once enabled, so the early checks run with no clock.
    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        clk_en = 1'b0;
        rst_n  = 1'b0;
        tb_in  = 5'b00000;
        tb_ir  = 16'h0000;
        tb_sel = 2'd0;
        tb_src = 1'b0;
        tb_ld  = 1'b0;
        #2;

        // Reset state, no clock
        check("rst_q", tb_out_q, 16'h0000);
        check("rst_vld", {15'd0, tb_out_q_vld}, 16'h0000);

        // Primary path, no clock running, reset held
        tb_in = 5'b11001; #1; check("out_11001", tb_out, 16'hFFF9);
        tb_in = 5'b00111; #1; check("out_00111", tb_out, 16'h0007);
        tb_in = 5'b10000; #1; check("out_min", tb_out, 16'hFFF0);
        tb_in = 5'b01111; #1; check("out_max", tb_out, 16'h000F);
        tb_in = 5'b11111; #1; check("out_m1", tb_out, 16'hFFFF);
        tb_in = 5'b00000; #1; check("out_zero", tb_out, 16'h0000);

        // Instruction field extraction
        tb_ir = 16'h0520; tb_sel = 2'd1; #1; check("ir_off6", tb_ir_ext, 16'hFFE0);
        tb_ir = 16'h0520; tb_sel = 2'd2; #1; check("ir_pc9", tb_ir_ext, 16'hFF20);
        tb_ir = 16'h0400; tb_sel = 2'd3; #1; check("ir_pc11_min", tb_ir_ext, 16'hFC00);
        tb_ir = 16'h03FF; tb_sel = 2'd3; #1; check("ir_pc11_max", tb_ir_ext, 16'h03FF);
        tb_ir = 16'hFFEF; tb_sel = 2'd0; #1; check("ir_imm5_pos", tb_ir_ext, 16'h000F);
        tb_ir = 16'h0010; tb_sel = 2'd0; #1; check("ir_imm5_min", tb_ir_ext, 16'hFFF0);
        tb_ir = 16'hFFDF; tb_sel = 2'd1; #1; check("ir_off6_pos", tb_ir_ext, 16'h001F);
        tb_ir = 16'hFEFF; tb_sel = 2'd2; #1; check("ir_pc9_pos", tb_ir_ext, 16'h00FF);

        // Still in reset after clock starts; ld high must not load
        tb_in  = 5'b11001;
        tb_ld  = 1'b1;
        clk_en = 1'b1;
        @(posedge clk); #1;
        check("rst_ld_q", tb_out_q, 16'h0000);
        check("rst_ld_vld", {15'd0, tb_out_q_vld}, 16'h0000);

        // Release reset, load primary result
        @(negedge clk);
        rst_n  = 1'b1;
        tb_ld  = 1'b0;
        @(posedge clk); #1;
        check("idle_vld", {15'd0, tb_out_q_vld}, 16'h0000);
        @(negedge clk);
        tb_in  = 5'b11001;
        tb_src = 1'b0;
        tb_ld  = 1'b1;
        @(posedge clk); #1;
        check("ld_out_q", tb_out_q, 16'hFFF9);
        check("ld_out_vld", {15'd0, tb_out_q_vld}, 16'h0001);

        // Hold with ld=0 while inputs change
        tb_ld = 1'b0;
        tb_in = 5'b00111;
        @(posedge clk); @(posedge clk); #1;
        check("hold_q", tb_out_q, 16'hFFF9);
        check("hold_vld", {15'd0, tb_out_q_vld}, 16'h0001);

        // Load the instruction-field result
        @(negedge clk);
        tb_ir  = 16'h0400;
        tb_sel = 2'd3;
        tb_src = 1'b1;
        tb_ld  = 1'b1;
        @(posedge clk); #1;
        check("ld_ir_q", tb_out_q, 16'hFC00);
        tb_ld = 1'b0;

        // Mid-cycle asynchronous reset, no clock edge involved
        #1;
        rst_n = 1'b0;
        #1;
        check("async_q", tb_out_q, 16'h0000);
        check("async_vld", {15'd0, tb_out_q_vld}, 16'h0000);

        // Release and load again with primary source
        @(negedge clk);
        rst_n  = 1'b1;
        tb_in  = 5'b01111;
        tb_src = 1'b0;
        tb_ld  = 1'b1;
        @(posedge clk); #1;
        check("reld_q", tb_out_q, 16'h000F);
        check("reld_vld", {15'd0, tb_out_q_vld}, 16'h0001);
        tb_ld = 1'b0;

        @(negedge clk);
        clk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
